ucode_seq: RTL and testbench

Microprogram sequencer for the Robertson's multiplier control unit. It contains the 32-entry microcode store, the next-address and branch logic, the iteration counter and the start/done handshake. It sits directly upstream of the micro-program counter register: it reads the current `upc` and drives `upc_next` and `load_incr` back into that register. It also drives the datapath control strobes.

---
 rtl/ucode_pkg.sv | 75 +++++++
 rtl/ucode_rom.sv | 42 ++++
 rtl/ucode_seq.sv | 115 +++++++++++
 tb/tb_ucode_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
`default_nettype none
// ============================================================================
// ucode_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the Robertson's multiplier microprogram
// sequencer. It holds the branch type encoding, the microword layout, the
// named micro-addresses and a microword constructor used by the ROM.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
package ucode_pkg;

  // Micro-address width (32-entry store).
  localparam int unsigned UPC_W = 5;

  // Branch type carried by every microword.
  typedef enum logic [2:0] {
    CONT      = 3'd0,  // fall through (micro-PC increments)
    JMP       = 3'd1,  // unconditional load of target
    BR_NSTART = 3'd2,  // load target while start is low
    BR_NQ0    = 3'd3,  // load target when multiplier LSB is 0
    BR_CNTNZ  = 3'd4   // load target while iterations remain
  } branch_t;

  // Microword: branch control, target and the six datapath strobes.
  typedef struct packed {
    branch_t            branch;
    logic [UPC_W-1:0]   target;
    logic               ld_mcand;
    logic               ld_mplier;
    logic               clr_acc;
    logic               add;
    logic               sub;
    logic               shift;
  } uword_t;

  // Strobe bit masks, ordered {ld_mcand, ld_mplier, clr_acc, add, sub, shift}.
  localparam logic [5:0] S_NONE      = 6'b000000;
  localparam logic [5:0] S_LD_MCAND  = 6'b100000;
  localparam logic [5:0] S_LD_MPLIER = 6'b010000;
  localparam logic [5:0] S_CLR_ACC   = 6'b001000;
  localparam logic [5:0] S_ADD       = 6'b000100;
  localparam logic [5:0] S_SUB       = 6'b000010;
  localparam logic [5:0] S_SHIFT     = 6'b000001;

  // Named micro-addresses of the multiply microprogram.
  localparam logic [4:0] A_IDLE  = 5'd0;
  localparam logic [4:0] A_INIT  = 5'd1;
  localparam logic [4:0] A_TEST  = 5'd2;
  localparam logic [4:0] A_ADD   = 5'd3;
  localparam logic [4:0] A_SHF   = 5'd4;
  localparam logic [4:0] A_LOOP  = 5'd5;
  localparam logic [4:0] A_LTEST = 5'd6;
  localparam logic [4:0] A_SUB   = 5'd7;
  localparam logic [4:0] A_LSHF  = 5'd8;
  localparam logic [4:0] A_FIN   = 5'd9;

  // Build a microword from a branch type, a target and a strobe mask.
  function automatic uword_t mk_uword(input branch_t    br,
                                      input logic [4:0] tgt,
                                      input logic [5:0] strb);
    uword_t w;
    w.branch    = br;
    w.target    = tgt;
    w.ld_mcand  = strb[5];
    w.ld_mplier = strb[4];
    w.clr_acc   = strb[3];
    w.add       = strb[2];
    w.sub       = strb[1];
    w.shift     = strb[0];
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_rom.sv
`default_nettype none
// ============================================================================
// ucode_rom
// ----------------------------------------------------------------------------
// Combinational 32-entry microcode store for the Robertson's multiplier.
// Ports:
//   addr_i   in   5   micro-address (current upc)
//   uword_o  out  uword_t  microword at addr_i
// Unused addresses 10..31 jump back to IDLE with all strobes low, so a
// corrupted micro-PC recovers in one cycle.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module ucode_rom
  import ucode_pkg::*;
(
  input  logic [4:0] addr_i,
  output uword_t     uword_o
);

  always_comb begin
    uword_o = mk_uword(JMP, A_IDLE, S_NONE);
    case (addr_i)
      A_IDLE:  uword_o = mk_uword(BR_NSTART, A_IDLE, S_NONE);
      A_INIT:  uword_o = mk_uword(CONT, A_IDLE,
                                  S_LD_MCAND | S_LD_MPLIER | S_CLR_ACC);
      A_TEST:  uword_o = mk_uword(BR_NQ0, A_SHF, S_NONE);
      A_ADD:   uword_o = mk_uword(CONT, A_IDLE, S_ADD);
      A_SHF:   uword_o = mk_uword(CONT, A_IDLE, S_SHIFT);
      A_LOOP:  uword_o = mk_uword(BR_CNTNZ, A_TEST, S_NONE);
      // Final step: the sign bit of the multiplier has negative weight,
      // hence a subtract instead of an add.
      A_LTEST: uword_o = mk_uword(BR_NQ0, A_LSHF, S_NONE);
      A_SUB:   uword_o = mk_uword(CONT, A_IDLE, S_SUB);
      A_LSHF:  uword_o = mk_uword(CONT, A_IDLE, S_SHIFT);
      A_FIN:   uword_o = mk_uword(JMP, A_IDLE, S_NONE);
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ucode_seq.sv
`default_nettype none
// ============================================================================
// ucode_seq
// ----------------------------------------------------------------------------
// Microprogram sequencer for the Robertson's multiplier control unit:
// microcode store, next-address/branch logic, iteration counter and the
// start/done handshake. Sits upstream of an external micro-PC register.
// Ports:
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous active-high reset
//   start_i      in   1  multiply request, honoured only at upc==0
//   upc_i        in   5  current micro-address from the micro-PC
//   q0_i         in   1  multiplier LSB (used combinationally)
//   load_incr_o  out  1  1: micro-PC loads upc_next_o, 0: increments
//   upc_next_o   out  5  branch target
//   ld_mcand_o, ld_mplier_o, clr_acc_o   out  datapath load/clear strobes
//   add_o, sub_o, shift_o                out  ALU add/sub, {acc,mplier} ashr
//   busy_o       out  1  upc_i != 0
//   done_o       out  1  registered; product valid and held
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int WIDTH = 8  // operand width, 2..32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [4:0] upc_i,
  input  logic       q0_i,
  output logic       load_incr_o,
  output logic [4:0] upc_next_o,
  output logic       ld_mcand_o,
  output logic       ld_mplier_o,
  output logic       clr_acc_o,
  output logic       add_o,
  output logic       sub_o,
  output logic       shift_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  uword_t           uword;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;

  ucode_rom u_rom (
    .addr_i  (upc_i),
    .uword_o (uword)
  );

  // Strobes come straight from the current microword.
  assign ld_mcand_o  = uword.ld_mcand;
  assign ld_mplier_o = uword.ld_mplier;
  assign clr_acc_o   = uword.clr_acc;
  assign add_o       = uword.add;
  assign sub_o       = uword.sub;
  assign shift_o     = uword.shift;

  assign upc_next_o  = uword.target;
  assign busy_o      = (upc_i != A_IDLE);
  assign done_o      = done_q;

  // Branch resolution.
  always_comb begin
    load_incr_o = 1'b1;
    case (uword.branch)
      CONT:      load_incr_o = 1'b0;
      JMP:       load_incr_o = 1'b1;
      BR_NSTART: load_incr_o = ~start_i;
      BR_NQ0:    load_incr_o = ~q0_i;
      BR_CNTNZ:  load_incr_o = (cnt_q != '0);
      default:   load_incr_o = 1'b1;  // unused encodings fall back to IDLE
    endcase
  end

  // Iteration counter: loaded at INIT, decremented at SHF. The zero guard
  // keeps it from wrapping if the micro-PC is ever steered to SHF directly.
  always_comb begin
    cnt_d = cnt_q;
    if (upc_i == A_INIT) begin
      cnt_d = CNT_INIT;
    end else if ((upc_i == A_SHF) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Completion flag: set leaving FIN, cleared when a new multiply is taken.
  // The two conditions are on different addresses so they never collide.
  always_comb begin
    done_d = done_q;
    if (upc_i == A_FIN) begin
      done_d = 1'b1;
    end else if ((upc_i == A_IDLE) && start_i) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucode_seq.sv
`default_nettype none
// ============================================================================
// tb_ucode_seq
// ----------------------------------------------------------------------------
// Self-checking bench for ucode_seq. Closes the upc loop with a micro-PC
// register (with a preset port used to steer upc to unused addresses).
// Expected micro-address traces are pushed to a queue when a multiply is
// requested and popped one per cycle against the observed upc.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module tb_ucode_seq;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       q0;
  logic [4:0] upc_q;
  logic       load_incr;
  logic [4:0] upc_next;
  logic       ld_mcand, ld_mplier, clr_acc, add, sub, shift;
  logic       busy, done;
  logic       preset_en;
  logic [4:0] preset_val;
  logic [5:0] strb;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign strb = {ld_mcand, ld_mplier, clr_acc, add, sub, shift};

  ucode_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .upc_i       (upc_q),
    .q0_i        (q0),
    .load_incr_o (load_incr),
    .upc_next_o  (upc_next),
    .ld_mcand_o  (ld_mcand),
    .ld_mplier_o (ld_mplier),
    .clr_acc_o   (clr_acc),
    .add_o       (add),
    .sub_o       (sub),
    .shift_o     (shift),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Micro-PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          upc_q <= 5'd0;
    else if (preset_en) upc_q <= preset_val;
    else if (load_incr) upc_q <= upc_next;
    else                upc_q <= upc_q + 5'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected strobes {ld_mcand, ld_mplier, clr_acc, add, sub, shift}.
  function automatic logic [5:0] exp_strb(input int a);
    case (a)
      1:       return 6'b111000;
      3:       return 6'b000100;
      4, 8:    return 6'b000001;
      7:       return 6'b000010;
      default: return 6'b000000;
    endcase
  endfunction

  // Address trace of one multiply with q0 held constant, ending back at 0.
  task automatic push_trace(input logic q0v);
    exp_q.push_back(1);
    for (int i = 0; i < WIDTH - 1; i++) begin
      exp_q.push_back(2);
      if (q0v) exp_q.push_back(3);
      exp_q.push_back(4);
      exp_q.push_back(5);
    end
    exp_q.push_back(6);
    if (q0v) exp_q.push_back(7);
    exp_q.push_back(8);
    exp_q.push_back(9);
    exp_q.push_back(0);
  endtask

  // Launch nruns multiplies from IDLE and check every cycle against the
  // scoreboard. Returns per-strobe activity counts.
  task automatic run_seq(input logic q0v, input int nruns, input logic hold,
                         output int nbusy, output int nadd,
                         output int nsub, output int nshf);
    int e;
    nbusy = 0; nadd = 0; nsub = 0; nshf = 0;
    total++;
    if (upc_q !== 5'd0) begin
      bad++; $display("FAIL run_from_idle upc=%0d want=0", upc_q);
    end
    q0 = q0v;
    start = 1'b1;
    for (int r = 0; r < nruns; r++) push_trace(q0v);
    tick;
    if (!hold) start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (upc_q !== 5'(e)) begin
        bad++; $display("FAIL trace_upc got=%0d want=%0d", upc_q, e);
      end
      total++;
      if (strb !== exp_strb(e)) begin
        bad++; $display("FAIL strobes upc=%0d got=%b want=%b", e, strb, exp_strb(e));
      end
      total++;
      if (done !== (e == 0)) begin
        bad++; $display("FAIL done_in_run upc=%0d got=%b want=%b", e, done, (e == 0));
      end
      total++;
      if (busy !== (e != 0)) begin
        bad++; $display("FAIL busy_in_run upc=%0d got=%b want=%b", e, busy, (e != 0));
      end
      if (busy === 1'b1)  nbusy++;
      if (add === 1'b1)   nadd++;
      if (sub === 1'b1)   nsub++;
      if (shift === 1'b1) nshf++;
      if (exp_q.size() > 0) tick;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; start = 1'b1; q0 = 1'b0;
    preset_en = 1'b0; preset_val = 5'd0;
    #3;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++;
    if (dut.cnt_q !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", dut.cnt_q); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++;
    if (strb !== 6'b0) begin bad++; $display("FAIL rst_strobes got=%b want=000000", strb); end
    total++;
    if (load_incr !== 1'b0 || upc_next !== 5'd0) begin
      bad++; $display("FAIL rst_branch load_incr=%b upc_next=%0d want 0/0", load_incr, upc_next);
    end
    @(negedge clk);
    reset = 1'b0;
    tick;
    total++;
    if (upc_q !== 5'd1) begin bad++; $display("FAIL rst_first_edge upc=%0d want=1", upc_q); end
    start = 1'b0;
    n = 0;
    while (upc_q !== 5'd0 && n < 100) begin tick; n++; end
    total++;
    if (upc_q !== 5'd0) begin bad++; $display("FAIL rst_run_timeout upc=%0d want=0", upc_q); end
  endtask

  task automatic test_q0_zero;
    int nb, na, ns, nh;
    run_seq(1'b0, 1, 1'b0, nb, na, ns, nh);
    total++;
    if (nb != WIDTH * 3 + 1) begin bad++; $display("FAIL q0z_busy got=%0d want=%0d", nb, WIDTH * 3 + 1); end
    total++;
    if (na != 0 || ns != 0) begin bad++; $display("FAIL q0z_addsub add=%0d sub=%0d want 0/0", na, ns); end
    total++;
    if (nh != WIDTH) begin bad++; $display("FAIL q0z_shift got=%0d want=%0d", nh, WIDTH); end
  endtask

  task automatic test_q0_one;
    int nb, na, ns, nh;
    run_seq(1'b1, 1, 1'b0, nb, na, ns, nh);
    total++;
    if (nb != WIDTH * 4 + 1) begin bad++; $display("FAIL q0o_busy got=%0d want=%0d", nb, WIDTH * 4 + 1); end
    total++;
    if (na != WIDTH - 1) begin bad++; $display("FAIL q0o_add got=%0d want=%0d", na, WIDTH - 1); end
    total++;
    if (ns != 1) begin bad++; $display("FAIL q0o_sub got=%0d want=1", ns); end
    total++;
    if (nh != WIDTH) begin bad++; $display("FAIL q0o_shift got=%0d want=%0d", nh, WIDTH); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL q0o_done got=%b want=1", done); end
  endtask

  task automatic test_done_hold;
    int nb, na, ns, nh;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++;
      if (done !== 1'b1 || upc_q !== 5'd0) begin
        bad++; $display("FAIL hold_done cyc=%0d done=%b upc=%0d want 1/0", i, done, upc_q);
      end
    end
    run_seq(1'b1, 1, 1'b0, nb, na, ns, nh);
  endtask

  task automatic test_back_to_back;
    int nb, na, ns, nh;
    run_seq(1'b0, 2, 1'b1, nb, na, ns, nh);
    total++;
    if (nb != 2 * (WIDTH * 3 + 1)) begin
      bad++; $display("FAIL b2b_busy got=%0d want=%0d", nb, 2 * (WIDTH * 3 + 1));
    end
    total++;
    if (nh != 2 * WIDTH) begin bad++; $display("FAIL b2b_shift got=%0d want=%0d", nh, 2 * WIDTH); end
  endtask

  task automatic test_reset_mid;
    logic found;
    // Idle with done high: reset must clear it without a clock edge.
    #2 reset = 1'b1;
    #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL idle_rst_done got=%b want=0", done); end
    @(negedge clk);
    reset = 1'b0;
    tick;
    q0 = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (upc_q === 5'd5 && dut.cnt_q === 3'd3) found = 1'b1;
      else tick;
    end
    total++;
    if (!found) begin bad++; $display("FAIL mid_reach upc=%0d cnt=%0d want 5/3", upc_q, dut.cnt_q); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (dut.cnt_q !== 3'd0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_rst cnt=%0d done=%b want 0/0", dut.cnt_q, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (upc_q !== 5'd0 || strb !== 6'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL mid_quiet cyc=%0d upc=%0d strb=%b busy=%b want 0/0/0", i, upc_q, strb, busy);
      end
    end
  endtask

  task automatic test_unused_addr;
    preset_val = 5'd20;
    preset_en  = 1'b1;
    tick;
    preset_en = 1'b0;
    total++;
    if (upc_q !== 5'd20) begin bad++; $display("FAIL u20_preset upc=%0d want=20", upc_q); end
    total++;
    if (load_incr !== 1'b1 || upc_next !== 5'd0) begin
      bad++; $display("FAIL u20_branch load_incr=%b upc_next=%0d want 1/0", load_incr, upc_next);
    end
    total++;
    if (strb !== 6'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL u20_strb strb=%b busy=%b want 000000/1", strb, busy);
    end
    tick;
    total++;
    if (upc_q !== 5'd0) begin bad++; $display("FAIL u20_return upc=%0d want=0", upc_q); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_q0_zero;
    test_q0_one;
    test_done_hold;
    test_back_to_back;
    test_reset_mid;
    test_unused_addr;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
